// File: rtl/button_debouncer.sv
// Debounces a raw button level: a new level is committed after STABLE_CNT consecutive enabled mismatching samples.
// Optional feature: define DEBOUNCER_SYNC_EN to put a 2-flop synchroniser in front of i_dat.
//
// state        | meaning
// -------------+------------------------------------------------
// ST_STABLE_LO | o_dat=0, no mismatching samples pending
// ST_PEND_HI   | o_dat=0, counting consecutive high samples
// ST_STABLE_HI | o_dat=1, no mismatching samples pending
// ST_PEND_LO   | o_dat=1, counting consecutive low samples
module button_debouncer #(
    parameter int STABLE_CNT = 16,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic i_arst,
    input  logic i_sclr,
    input  logic i_en,
    input  logic i_dat,
    output logic o_dat,
    output logic o_chg
);

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'b00,
        ST_PEND_HI   = 2'b01,
        ST_STABLE_HI = 2'b10,
        ST_PEND_LO   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             chg_q, chg_d;
    logic             s;
    logic             level;

`ifdef DEBOUNCER_SYNC_EN
    logic sync1_q, sync2_q;

    // Shifts on every edge, independent of the sample enable.
    always_ff @(posedge clk or posedge i_arst) begin
        if (i_arst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else if (i_sclr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_dat;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = i_dat;
`endif

    assign level = (state_q == ST_STABLE_HI) || (state_q == ST_PEND_LO);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chg_d   = 1'b0;
        if (i_en) begin
            if (s == level) begin
                cnt_d   = '0;
                state_d = level ? ST_STABLE_HI : ST_STABLE_LO;
            end else if (cnt_q == CNT_MAX) begin
                cnt_d   = '0;
                chg_d   = 1'b1;
                state_d = level ? ST_STABLE_LO : ST_STABLE_HI;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = level ? ST_PEND_LO : ST_PEND_HI;
            end
        end
    end

    always_ff @(posedge clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= ST_STABLE_LO;
            cnt_q   <= '0;
            chg_q   <= 1'b0;
        end else if (i_sclr) begin
            state_q <= ST_STABLE_LO;
            cnt_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chg_q   <= chg_d;
        end
    end

    assign o_dat = level;
    assign o_chg = chg_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random stimulus against a run-length model.
// Two instances share the inputs: STABLE_CNT=4 and the STABLE_CNT=1 boundary.
module tb_button_debouncer;

`ifdef DEBOUNCER_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif
    localparam int N0  = 4;
    localparam int LAT = SYNC ? N0 + 1 : N0 - 1;

    logic clk = 1'b0;
    logic i_arst, i_sclr, i_en, i_dat;
    logic o_dat0, o_chg0, o_dat1, o_chg1;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    int   m_n   [2] = '{N0, 1};
    int   m_run [2];
    logic m_lvl [2], m_chg [2], m_sh1 [2], m_sh2 [2];

    button_debouncer #(.STABLE_CNT(N0), .CNT_W(2)) dut0 (
        .clk(clk), .i_arst(i_arst), .i_sclr(i_sclr), .i_en(i_en),
        .i_dat(i_dat), .o_dat(o_dat0), .o_chg(o_chg0)
    );

    button_debouncer #(.STABLE_CNT(1), .CNT_W(1)) dut1 (
        .clk(clk), .i_arst(i_arst), .i_sclr(i_sclr), .i_en(i_en),
        .i_dat(i_dat), .o_dat(o_dat1), .o_chg(o_chg1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_run[d] = 0; m_lvl[d] = 1'b0; m_chg[d] = 1'b0;
            m_sh1[d] = 1'b0; m_sh2[d] = 1'b0;
        end
    endtask

    // A level commits once m_n consecutive enabled samples disagree with it.
    task automatic model_edge(input logic en, input logic dat, input logic sclr);
        logic s;
        for (int d = 0; d < 2; d++) begin
            s = SYNC ? m_sh2[d] : dat;
            if (sclr) begin
                m_run[d] = 0; m_lvl[d] = 1'b0; m_chg[d] = 1'b0;
                m_sh1[d] = 1'b0; m_sh2[d] = 1'b0;
            end else begin
                m_sh2[d] = m_sh1[d];
                m_sh1[d] = dat;
                m_chg[d] = 1'b0;
                if (en) begin
                    if (s !== m_lvl[d]) begin
                        m_run[d]++;
                        if (m_run[d] == m_n[d]) begin
                            m_lvl[d] = ~m_lvl[d];
                            m_run[d] = 0;
                            m_chg[d] = 1'b1;
                        end
                    end else begin
                        m_run[d] = 0;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic en, input logic dat, input logic sclr);
        i_en = en; i_dat = dat; i_sclr = sclr;
        @(posedge clk);
        model_edge(en, dat, sclr);
        #1;
        check("o_dat_n4", o_dat0, m_lvl[0]);
        check("o_chg_n4", o_chg0, m_chg[0]);
        check("o_dat_n1", o_dat1, m_lvl[1]);
        check("o_chg_n1", o_chg1, m_chg[1]);
    endtask

    // Called just after a clock edge; the pulse ends well before the next edge.
    task automatic pulse_arst(input string tag);
        i_arst = 1'b1;
        #1;
        model_reset();
        check({tag, "_o_dat"}, {o_dat0, o_dat1}, 2'b00);
        check({tag, "_o_chg"}, {o_chg0, o_chg1}, 2'b00);
        #2;
        i_arst = 1'b0;
    endtask

    task automatic measure(input string tag, input logic dat, input logic target);
        int n = 0;
        do begin
            step(1'b1, dat, 1'b0);
            n++;
        end while (o_dat0 !== target && n < 20);
        check(tag, n, 1 + LAT);
    endtask

    initial begin
        int pulses;
        logic dat;
        logic bounce [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        i_arst = 1'b1; i_sclr = 1'b0; i_en = 1'b1; i_dat = 1'b1;
        #1;
        model_reset();
        check("reset_o_dat", {o_dat0, o_dat1}, 2'b00);
        check("reset_o_chg", {o_chg0, o_chg1}, 2'b00);
        #2;
        i_arst = 1'b0;
        i_dat  = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        measure("press_latency", 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        measure("release_latency", 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0);

        measure("press2_latency", 1'b1, 1'b1);
        pulse_arst("arst_high");
        measure("held_through_reset", 1'b1, 1'b1);

        step(1'b1, 1'b0, 1'b1);
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, (i < 8) ? bounce[i] : 1'b1, 1'b0);
            pulses += int'(o_chg0);
        end
        check("bounce_pulses", pulses, 1);
        check("bounce_level", o_dat0, 1'b1);

        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) step((i % 3) == 2, 1'b1, 1'b0);

        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 12 && m_run[0] != 2; i++) step(1'b1, 1'b1, 1'b0);
        check("midcount_reached", m_run[0], 2);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);

        dat = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) dat = ~dat;
            step($urandom_range(0, 3) != 0, dat, $urandom_range(0, 49) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
